// File: rtl/sync_pulse.sv
// Free-running periodic sync pulse: start delay after reset, then WIDTH-active / PERIOD-WIDTH-inactive forever.
// Define SYNC_ACTIVE_LOW_EN to make the pulse active-low (idle level 1).
module sync_pulse #(
    parameter int PERIOD    = 8,
    parameter int WIDTH     = 2,
    parameter int START_DLY = 3
) (
    input  logic clk,
    input  logic rst,
    output logic out
);

    localparam int CNT_MAX = (PERIOD > START_DLY + 1) ? PERIOD : START_DLY + 1;
    localparam int CNT_W   = $clog2(CNT_MAX);

    // START_DLY of 0 and 1 both fire on the first edge after release.
    localparam logic [CNT_W-1:0] START_LAST = (START_DLY == 0) ? '0 : CNT_W'(START_DLY - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(PERIOD - WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef SYNC_ACTIVE_LOW_EN
    localparam logic ACTIVE = 1'b0;
`else
    localparam logic ACTIVE = 1'b1;
`endif

    if (PERIOD < 2 || WIDTH < 1 || WIDTH >= PERIOD || START_DLY < 0) begin : g_bad_params
        $error("sync_pulse: illegal parameters PERIOD=%0d WIDTH=%0d START_DLY=%0d",
               PERIOD, WIDTH, START_DLY);
    end

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             out_q,   out_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            ST_START: begin
                if (cnt_q == START_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    out_d   = ACTIVE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    out_d   = ~ACTIVE;
                end
            end
            ST_HIGH: begin
                if (cnt_q == HIGH_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    out_d   = ~ACTIVE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    out_d   = ACTIVE;
                end
            end
            ST_LOW: begin
                if (cnt_q == LOW_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    out_d   = ACTIVE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    out_d   = ~ACTIVE;
                end
            end
            default: begin
                state_d = ST_START;
                cnt_d   = '0;
                out_d   = ~ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            out_q   <= ~ACTIVE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_sync_pulse.sv
// Directed bench for sync_pulse: three configurations share clock and reset, each checked
// against hand-computed per-edge activity vectors (bit n-1 = active after edge n).
module tb_sync_pulse;

`ifdef SYNC_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    // Defaults (P8 W2 D3): edges 3-4, 11-12, ... ; P2 W1 D0: odd edges; P5 W4 D1: all but 5,10,15,...
    localparam logic [31:0] VEC_DEF = 32'h0C0C_0C0C;
    localparam logic [31:0] VEC_SQ  = 32'h5555_5555;
    localparam logic [31:0] VEC_P5  = 32'hDEF7_BDEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic out_def, out_sq, out_p5;
    logic [2:0] outs;
    int edge_cnt;
    int checks = 0;
    int failures = 0;

    sync_pulse dut_def (.clk(clk), .rst(rst), .out(out_def));
    sync_pulse #(.PERIOD(2), .WIDTH(1), .START_DLY(0)) dut_sq (.clk(clk), .rst(rst), .out(out_sq));
    sync_pulse #(.PERIOD(5), .WIDTH(4), .START_DLY(1)) dut_p5 (.clk(clk), .rst(rst), .out(out_p5));

    assign outs = {out_p5, out_sq, out_def};

    always begin
        clk = 1'b1;
        #50;
        clk = 1'b0;
        #50;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    function automatic logic exp_for(input int d, input int n);
        logic [31:0] vec;
        case (d)
            0:       vec = VEC_DEF;
            1:       vec = VEC_SQ;
            default: vec = VEC_P5;
        endcase
        if (n <= 0) return INV;
        if (n > 32) return 1'bx;
        return vec[n-1] ^ INV;
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            #(k == 0 ? 15 : 40);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (outs[d] !== INV) begin
                    failures++;
                    $display("[TB] FAIL reset_level dut=%0d t=%0t got=%b expected=%b", d, $time, outs[d], INV);
                end
            end
        end
        #15;
        rst = 1'b1;
    endtask

    task automatic test_pulse_train();
        int active_p5;
        active_p5 = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #10;
            if (n >= 6 && n <= 10 && out_p5 === ~INV) active_p5++;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (outs[d] !== exp_for(d, n)) begin
                    failures++;
                    $display("[TB] FAIL train dut=%0d edge=%0d got=%b expected=%b", d, n, outs[d], exp_for(d, n));
                end
            end
        end
        checks++;
        if (active_p5 != 4) begin
            failures++;
            $display("[TB] FAIL p5_duty got=%0d active cycles expected=4", active_p5);
        end
    endtask

    task automatic test_reset_mid_high();
        rst = 1'b0;
        #60;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #50;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (outs[d] !== exp_for(d, 3)) begin
                failures++;
                $display("[TB] FAIL pre_mid_reset dut=%0d got=%b expected=%b", d, outs[d], exp_for(d, 3));
            end
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (outs[d] !== INV) begin
                failures++;
                $display("[TB] FAIL async_clear dut=%0d got=%b expected=%b", d, outs[d], INV);
            end
        end
        #19;
        rst = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            #10;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (outs[d] !== exp_for(d, n)) begin
                    failures++;
                    $display("[TB] FAIL restart dut=%0d edge=%0d got=%b expected=%b", d, n, outs[d], exp_for(d, n));
                end
            end
        end
    endtask

    // Reset every 670 units so the release phase drifts against the clock.
    task automatic test_periodic_reset();
        for (int w = 0; w < 5; w++) begin
            rst = 1'b0;
            #35;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (outs[d] !== INV) begin
                    failures++;
                    $display("[TB] FAIL periodic_reset dut=%0d win=%0d got=%b expected=%b", d, w, outs[d], INV);
                end
            end
            #35;
            rst = 1'b1;
            #5;
            for (int s = 0; s < 59; s++) begin
                for (int d = 0; d < 3; d++) begin
                    checks++;
                    if (outs[d] !== exp_for(d, edge_cnt)) begin
                        failures++;
                        $display("[TB] FAIL periodic dut=%0d win=%0d edge=%0d t=%0t got=%b expected=%b",
                                 d, w, edge_cnt, $time, outs[d], exp_for(d, edge_cnt));
                    end
                end
                #10;
            end
            #5;
        end
    endtask

    initial begin
        test_reset();
        test_pulse_train();
        test_reset_mid_high();
        test_periodic_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_pulse.md
# sync_pulse

Periodic synchronization-pulse generator for the `sync` block. After reset release it waits a fixed start delay, then emits a registered pulse train on `out`: WIDTH cycles active, PERIOD−WIDTH cycles inactive, repeating indefinitely. It has no data inputs and serves as a free-running timing reference (frame/line sync, strobe) for downstream logic in the same clock domain.

## Interface
- PERIOD, 8, pulse repetition period in clock cycles; legal range ≥ 2.
- WIDTH, 2, active pulse width in cycles; legal range 1 ≤ WIDTH < PERIOD.
- START_DLY, 3, cycles from reset release to the first active pulse; legal range ≥ 0.
- CNT_W, derived as $clog2 of max(PERIOD, START_DLY+1); not overridden.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- out  output 1  registered sync pulse; active level is 1 unless the configuration macro is defined.

## Operation
- State machine with three states:
  - START: count start delay.
  - HIGH: out active.
  - LOW: out inactive.
- Single counter `cnt` (CNT_W bits), reused per state.
- Reset (rst=0, asynchronous): state=START, cnt=0, out=inactive; held while rst=0.
- START: on each edge cnt++. On the edge where START_DLY edges have elapsed, go to HIGH, out=active, cnt=0. If START_DLY=0, enter HIGH on the first edge after release.
- HIGH: out active for exactly WIDTH edges, then LOW, out inactive, cnt=0.
- LOW: out inactive for exactly PERIOD−WIDTH edges, then HIGH, out active, cnt=0.
- Counter never wraps past its terminal value; terminal comparisons use equality against the parameter minus 1.
- Illegal parameters (WIDTH=0, WIDTH≥PERIOD, PERIOD<2) are rejected at elaboration with an error message.
- Unreachable state encodings return to START with out inactive on the next edge.

## Timing
- Edge n = nth rising clk edge with rst=1 after release.
- out is a flop output with no combinational path from rst deassertion; assertion of reset clears out immediately (asynchronous).
- First active edge: n = START_DLY (n=1 when START_DLY=0).
- Active interval: edges START_DLY … START_DLY+WIDTH−1. Inactive from edge START_DLY+WIDTH.
- Next rise: START_DLY+PERIOD. Thereafter period exactly PERIOD cycles, duty WIDTH/PERIOD, no jitter.
- Reset mid-pulse or mid-delay: out inactive at once; sequence restarts from START on release, with the full START_DLY applied again.
- Reset release coincident with a clock edge: that edge does not count. The first counted edge is the next one.

## Configuration
- SYNC_ACTIVE_LOW_EN:
  - Defined: out is inverted. Idle/reset level is 1 and the pulse is 0 for WIDTH cycles.
  - Undefined: active-high; reset/idle level 0.
  - Timing identical in both cases. Inversion is applied before the output flop, so out stays registered.

## Test plan
- Defaults, 100-unit clock, rst=0 from t=0 to t=70, edges at 0,100,…:
  - out=0 during reset.
  - out rises at t=300 and falls at t=500.
  - out rises again at t=1100 and t=1900.
- Reset pulse every 670 units (rst=0 for 70): out forced to 0 within each low window. Each release restarts with the first rise 3 edges later. Run to t=4000 with no X on out.
- Assert rst=0 mid-HIGH (t=350) → out=0 immediately, before any clock edge. After release, START_DLY is re-applied.
- START_DLY=0, PERIOD=2, WIDTH=1 → out high on edge 1 and toggles every cycle thereafter (50% square wave).
- PERIOD=5, WIDTH=4, START_DLY=1 → high edges 1–4, low edge 5, high edges 6–9; count 4 active cycles per 5.
- SYNC_ACTIVE_LOW_EN defined, defaults → out=1 in reset, 0 on edges 3–4, 1 from edge 5, 0 again from edge 11.
